// File: rtl/ad9739a_spi_slave.sv
// ad9739a_spi_slave
//   SPI responder emulating the AD9739A control port. It sits at the far end of
//   the DAC configuration SPI master and holds a byte-wide register file. It is
//   used for board-to-board loopback and for bench checks of the DAC init sequence.
//   The SPI pins are oversampled in the clk domain, so clk must be >= 4x spi_clk.
//
//   Optional feature macro: AD9739A_SPI_STATUS_EN
//     When defined, reads of 0x2A return status_in, sampled when the byte is
//     loaded. Writes to 0x2A are dropped without reg_wr_en.
//     When not defined, status_in is absent and 0x2A is an ordinary register.
//
//   Ports
//     clk, rst_n        system clock, async active-low reset
//     spi_csn/clk/mosi  SPI mode 0 inputs (raw, asynchronous to clk)
//     spi_miso/_oe      serial read data, MSB first, and its drive enable
//     reg_wr_en/addr/data  one-clk pulse per committed write
//     busy              frame in progress (synced csn low)
//     err_addr          one-clk pulse on access to addr >= REG_NUM
//     status_in         live status byte (AD9739A_SPI_STATUS_EN only)
//
//   state   | meaning
//   IDLE    | csn high, waiting for a frame
//   INSTR   | shifting the instruction byte {R/Wn, A[6:0]}
//   DATA    | streaming data bytes, address increments after each byte

module ad9739a_spi_slave #(
  parameter int REG_NUM     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       reg_wr_en,
  output logic [6:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy,
  output logic       err_addr
`ifdef AD9739A_SPI_STATUS_EN
  ,
  input  logic [7:0] status_in
`endif
);

  localparam logic [7:0] REG_NUM_W = 8'(REG_NUM);

  typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_DATA} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] addr_q, addr_d;
  logic       rnw_q, rnw_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       err_q, err_d;
  logic [7:0] regs_q [REG_NUM];
  logic [7:0] regs_d [REG_NUM];

  logic       csn_s, sclk_s, mosi_s;
  logic       sclk_rise, sclk_fall;
  logic [7:0] byte_in;
  logic [6:0] load_addr;
  logic [7:0] rd_val;
  logic       load_valid;
  logic       wr_valid;
  logic       wr_status;

  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign byte_in   = {shift_q, mosi_s};

  // A read instruction loads its own address; a completed data byte loads the next one.
  assign load_addr = (state_q == ST_INSTR) ? byte_in[6:0] : addr_q + 7'd1;

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < REG_NUM; i++) begin
      if (load_addr == 7'(i)) rd_val = regs_q[i];
    end
    load_valid = ({1'b0, load_addr} < REG_NUM_W);
    wr_valid   = ({1'b0, addr_q} < REG_NUM_W);
    wr_status  = 1'b0;
`ifdef AD9739A_SPI_STATUS_EN
    if (load_addr == 7'h2A) begin
      rd_val     = status_in;
      load_valid = 1'b1;
    end
    wr_status = (addr_q == 7'h2A);
`endif
  end

  always_comb begin
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    rnw_d     = rnw_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    regs_d    = regs_q;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        miso_d    = 1'b0;
        oe_d      = 1'b0;
        if (!csn_s) state_d = ST_INSTR;
      end
      ST_INSTR, ST_DATA: begin
        // Rises are still honoured in the cycle csn is seen high, so a byte
        // completing together with csn rise commits before returning to IDLE.
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = byte_in[6:0];
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_INSTR) begin
              state_d = ST_DATA;
              rnw_d   = byte_in[7];
              addr_d  = byte_in[6:0];
              if (byte_in[7]) begin
                tx_d  = load_valid ? rd_val : 8'h00;
                err_d = ~load_valid;
                oe_d  = 1'b1;
              end
            end else begin
              addr_d = addr_q + 7'd1;
              if (rnw_q) begin
                tx_d  = load_valid ? rd_val : 8'h00;
                err_d = ~load_valid;
              end else if (!wr_valid) begin
                err_d = 1'b1;
              end else if (!wr_status) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = byte_in;
                if (addr_q == 7'h00 && byte_in[5]) begin
                  for (int i = 0; i < REG_NUM; i++) regs_d[i] = 8'h00;
                end else begin
                  for (int i = 0; i < REG_NUM; i++) begin
                    if (addr_q == 7'(i)) regs_d[i] = byte_in;
                  end
                end
              end
            end
          end
        end
        if (sclk_fall && state_q == ST_DATA && rnw_q) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        if (csn_s) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      addr_q      <= 7'd0;
      rnw_q       <= 1'b0;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'h00;
      err_q       <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      csn_sync_q  <= csn_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rnw_q       <= rnw_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      regs_q      <= regs_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign err_addr    = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ad9739a_spi_slave.sv
module tb_ad9739a_spi_slave;
  localparam int HALF    = 50;
  localparam int REG_NUM = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, reg_wr_en, busy, err_addr;
  logic [6:0] reg_wr_addr;
  logic [7:0] reg_wr_data;

  ad9739a_spi_slave #(.REG_NUM(REG_NUM), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_csn(spi_csn), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int err_cnt = 0;
  int exp_err = 0;
  logic [14:0] obs_q[$];
  logic [14:0] exp_q[$];
  logic [7:0]  model[128];
  logic [7:0]  tx_buf[64];
  logic [7:0]  rx_buf[64];
  logic        last_oe;

  always @(negedge clk) begin
    if (reg_wr_en) obs_q.push_back({reg_wr_addr, reg_wr_data});
    if (err_addr) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      #HALF;
      spi_clk = 1'b1;
      r[i] = spi_miso;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic rnw, input logic [6:0] a, input int n);
    logic [7:0] d;
    spi_csn = 1'b0;
    #(2*HALF);
    spi_byte({rnw, a}, d);
    for (int i = 0; i < n; i++) begin
      spi_byte(rnw ? 8'h00 : tx_buf[i], d);
      rx_buf[i] = d;
    end
    #HALF;
    last_oe = spi_miso_oe;
    spi_csn = 1'b1;
    #(4*HALF);
  endtask

  // Reference: a flat 128-entry address space, only 0..REG_NUM-1 is storage.
  function automatic logic [7:0] model_read(input logic [6:0] a);
    return (int'(a) < REG_NUM) ? model[a] : 8'h00;
  endfunction

  task automatic check_pulses(input string tag);
    int n;
    check({tag, "_wr_cnt"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr_pulse"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input string tag, input logic [6:0] a, input int n);
    int err0;
    int exp_e;
    logic [6:0] ad;
    err0 = err_cnt;
    exp_e = 0;
    spi_frame(1'b0, a, n);
    for (int i = 0; i < n; i++) begin
      ad = a + 7'(i);
      if (int'(ad) < REG_NUM) begin
        exp_q.push_back({ad, tx_buf[i]});
        if (ad == 7'h00 && tx_buf[i][5]) begin
          for (int k = 0; k < 128; k++) model[k] = 8'h00;
        end else begin
          model[ad] = tx_buf[i];
        end
      end else begin
        exp_e++;
      end
    end
    check_pulses(tag);
    check({tag, "_err"}, err_cnt - err0, exp_e);
    check({tag, "_oe"}, last_oe, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [6:0] a, input int n);
    spi_frame(1'b1, a, n);
    for (int i = 0; i < n; i++) check({tag, "_rd"}, rx_buf[i], model_read(a + 7'(i)));
    check({tag, "_oe"}, last_oe, 1'b1);
    check({tag, "_oe_idle"}, spi_miso_oe, 1'b0);
    check({tag, "_no_wr"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    for (int k = 0; k < 128; k++) model[k] = 8'h00;
    #33;
    check("rst_miso", spi_miso, 1'b0);
    check("rst_oe", spi_miso_oe, 1'b0);
    check("rst_wr_en", reg_wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_addr, 1'b0);
    rst_n = 1'b1;
    #100;

    tx_buf[0] = 8'h5A;
    do_write("w00", 7'h00, 1);
    do_read("r00", 7'h00, 1);
    check("r00_val", rx_buf[0], 8'h5A);

    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
    do_write("ws10", 7'h10, 3);
    do_read("rs10", 7'h10, 3);

    // Stream across 0x7F: first byte is out of range here, second wraps to 0x00.
    tx_buf[0] = 8'($urandom); tx_buf[1] = 8'($urandom) & 8'hDF;
    do_write("wrap", 7'h7F, 2);
    do_read("wrap", 7'h00, 1);

    tx_buf[0] = 8'hFF;
    do_write("w50", 7'h50, 1);
    do_read("r50", 7'h50, 1);

    tx_buf[0] = 8'h3C;
    do_write("w05", 7'h05, 1);
    spi_csn = 1'b0;
    #(2*HALF);
    spi_byte(8'h05, d);
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b1; #HALF; spi_clk = 1'b1; #HALF; spi_clk = 1'b0;
    end
    check("part_busy", busy, 1'b1);
    #HALF;
    spi_csn = 1'b1;
    #(4*HALF);
    check("part_busy_fall", busy, 1'b0);
    check_pulses("part");
    do_read("part", 7'h05, 1);

    for (int t = 0; t < 16; t++) begin
      logic [6:0] a;
      int n;
      a = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      do_write("rnd", a, n);
      do_read("rnd", a, n);
    end

    for (int i = 0; i < 63; i++) tx_buf[i] = 8'($urandom) | 8'h01;
    do_write("fill", 7'h01, 63);
    tx_buf[0] = 8'h20;
    do_write("softrst", 7'h00, 1);
    do_read("softrst", 7'h00, 64);
    for (int i = 0; i < 64; i++) check("softrst_zero", rx_buf[i], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
